// File: rtl/order_delete_parser_param_if.sv
// Beat-stream input and decoded Order Delete fields exchanged between the
// message-type dispatcher (master) and the 'D' body parser (slave).
interface order_delete_parser_param_if #(
  parameter int DATA_W = 64
);
  localparam int BYTES = DATA_W / 8;
  localparam int TRK_W = $clog2(BYTES);

  logic [DATA_W-1:0] dataIn;
  logic              dataValid;
  logic [TRK_W-1:0]  trackerIn;
  logic              startOrderDelete;

  logic              busy;
  logic              msgValid;
  logic [31:0]       timeStamp;
  logic [63:0]       orderID;
  logic [31:0]       orderBookID;
  logic [7:0]        side;
  logic              sideErr;
  logic [TRK_W-1:0]  trackerOut;
  logic              lastLaneUsed;

  modport master (
    output dataIn, dataValid, trackerIn, startOrderDelete,
    input  busy, msgValid, timeStamp, orderID, orderBookID, side,
           sideErr, trackerOut, lastLaneUsed
  );

  modport slave (
    input  dataIn, dataValid, trackerIn, startOrderDelete,
    output busy, msgValid, timeStamp, orderID, orderBookID, side,
           sideErr, trackerOut, lastLaneUsed
  );
endinterface

// File: rtl/order_delete_parser_param.sv
// ITCH Order Delete body parser: gathers 17 body bytes from any start lane; msgValid one cycle
// after the final byte is sampled. dataValid low stalls collection one cycle per idle beat.
module order_delete_parser_param #(
  parameter int DATA_W = 64
) (
  input logic                     clk,
  input logic                     rst,
  order_delete_parser_param_if.slave bus
);
  localparam int BYTES = DATA_W / 8;
  localparam int TRK_W = $clog2(BYTES);
  localparam logic [4:0] BYTES5   = 5'(BYTES);
  localparam logic [4:0] BODY_LEN = 5'd17;

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] COLLECT = 1'b1;

  logic [0:0]       state;
  logic [4:0]       count;
  logic [135:0]     asmBuf;

  logic             msgValidR;
  logic [31:0]      timeStampR;
  logic [63:0]      orderIDR;
  logic [31:0]      orderBookIDR;
  logic [7:0]       sideR;
  logic             sideErrR;
  logic [TRK_W-1:0] trackerOutR;
  logic             lastLaneUsedR;

  logic             inIdle;
  logic             accept;
  logic             done;
  logic [TRK_W-1:0] baseLane;
  logic [4:0]       baseCnt;
  logic [135:0]     baseBuf;
  logic [4:0]       avail;
  logic [4:0]       need;
  logic [4:0]       take;
  logic [4:0]       nxtCnt;
  logic [4:0]       endLane;
  logic [DATA_W-1:0] aligned;
  logic [DATA_W-1:0] piece;
  logic [135:0]     nxtBuf;

  assign inIdle   = (state == IDLE);
  assign accept   = bus.dataValid & (inIdle ? bus.startOrderDelete : 1'b1);
  assign baseLane = inIdle ? bus.trackerIn : '0;
  assign baseCnt  = inIdle ? 5'd0 : count;
  assign baseBuf  = inIdle ? '0 : asmBuf;

  assign avail = BYTES5 - 5'(baseLane);
  assign need  = BODY_LEN - baseCnt;
  assign take  = (avail < need) ? avail : need;

  // Left-justify the useful lanes, then drop everything past the bytes we take.
  assign aligned = bus.dataIn << {baseLane, 3'b000};
  assign piece   = aligned >> {BYTES5 - take, 3'b000};
  assign nxtBuf  = (baseBuf << {take, 3'b000}) | {{(136-DATA_W){1'b0}}, piece};

  assign nxtCnt  = baseCnt + take;
  assign endLane = 5'(baseLane) + take;
  assign done    = accept && (nxtCnt == BODY_LEN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      count         <= 5'd0;
      asmBuf        <= '0;
      msgValidR     <= 1'b0;
      timeStampR    <= '0;
      orderIDR      <= '0;
      orderBookIDR  <= '0;
      sideR         <= '0;
      sideErrR      <= 1'b0;
      trackerOutR   <= '0;
      lastLaneUsedR <= 1'b0;
    end else begin
      msgValidR <= done;
      if (accept) begin
        asmBuf <= nxtBuf;
        count  <= done ? 5'd0 : nxtCnt;
        state  <= done ? IDLE : COLLECT;
      end
      if (done) begin
        timeStampR    <= nxtBuf[135:104];
        orderIDR      <= nxtBuf[103:40];
        orderBookIDR  <= nxtBuf[39:8];
        sideR         <= nxtBuf[7:0];
        sideErrR      <= !((nxtBuf[7:0] == 8'h42) || (nxtBuf[7:0] == 8'h53));
        trackerOutR   <= endLane[TRK_W-1:0];
        lastLaneUsedR <= (endLane == BYTES5);
      end
    end
  end

  assign bus.busy         = (state == COLLECT);
  assign bus.msgValid     = msgValidR;
  assign bus.timeStamp    = timeStampR;
  assign bus.orderID      = orderIDR;
  assign bus.orderBookID  = orderBookIDR;
  assign bus.side         = sideR;
  assign bus.sideErr      = sideErrR;
  assign bus.trackerOut   = trackerOutR;
  assign bus.lastLaneUsed = lastLaneUsedR;
endmodule
